// File: rtl/kmeans_regfile.sv
// K-means host register file: exposes the centroid registers, the start/done
// handshake, the point window and a RAM preload port to a host bus, and lets
// the clustering controller update centroids while a run is in progress.
module kmeans_regfile #(
    parameter int dataWidth    = 91,
    parameter int reg_amount   = 4,
    parameter int addrWidth    = 9,
    parameter int ram_word_len = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    host_req,
    input  logic                    host_wr,
    input  logic [reg_amount-1:0]   host_addr,
    input  logic [dataWidth-1:0]    host_wdata,
    output logic                    host_ack,
    output logic [dataWidth-1:0]    host_rdata,
    output logic                    irq,
    output logic                    go,
    input  logic [reg_amount-1:0]   reg_num,
    input  logic                    reg_write,
    input  logic [dataWidth-1:0]    ctrl_wdata,
    output logic [dataWidth-1:0]    ctrl_rdata,
    input  logic                    interupt,
    output logic [addrWidth-1:0]    first_ram_addr,
    output logic [addrWidth-1:0]    last_ram_addr,
    output logic                    ram_load,
    output logic [addrWidth-1:0]    ram_load_addr,
    output logic [ram_word_len-1:0] ram_load_data
);

    logic [dataWidth-1:0] cent [8];
    logic [dataWidth-1:0] ram_data;
    logic [dataWidth-1:0] first_reg;
    logic [dataWidth-1:0] last_reg;
    logic [addrWidth-1:0] ram_addr;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 int_q;

    logic                 accept;
    logic                 host_write;
    logic                 rise;
    logic [dataWidth-1:0] read_value;
    int unsigned          haddr;
    int unsigned          cidx;

    // A new access is taken only when no ack is outstanding, so a held request
    // completes on every second cycle.
    assign accept     = host_req & ~host_ack;
    assign host_write = accept & host_wr;
    assign rise       = interupt & ~int_q;

    assign irq            = done;
    assign first_ram_addr = first_reg[addrWidth-1:0];
    assign last_ram_addr  = last_reg[addrWidth-1:0];

    // Decode both register indices and build the host and controller read views.
    always_comb begin
        haddr      = 32'(host_addr);
        cidx       = 32'(reg_num);
        read_value = '0;
        case (haddr)
            0:                      read_value = dataWidth'({err, busy, done});
            1:                      read_value = dataWidth'(go);
            2, 3, 4, 5, 6, 7, 8, 9: read_value = cent[3'(haddr - 2)];
            10:                     read_value = dataWidth'(ram_addr);
            11:                     read_value = ram_data;
            12:                     read_value = first_reg;
            13:                     read_value = last_reg;
            default:                read_value = '0;
        endcase
        ctrl_rdata = '0;
        if (cidx >= 2 && cidx <= 9) begin
            ctrl_rdata = cent[3'(cidx - 2)];
        end
    end

    // Register state: host accesses, controller centroid updates and the
    // done handshake. Later assignments take priority, so a controller update
    // overrides a host write and an interrupt edge overrides a done clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cent[i] <= '0;
            end
            ram_data      <= '0;
            first_reg     <= '0;
            last_reg      <= '0;
            ram_addr      <= '0;
            go            <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            int_q         <= 1'b0;
            host_ack      <= 1'b0;
            host_rdata    <= '0;
            ram_load      <= 1'b0;
            ram_load_addr <= '0;
            ram_load_data <= '0;
        end else begin
            int_q    <= interupt;
            host_ack <= accept;
            ram_load <= 1'b0;
            if (accept) begin
                host_rdata <= read_value;
            end
            if (host_write) begin
                if (haddr == 0) begin
                    if (host_wdata[0]) done <= 1'b0;
                    if (host_wdata[2]) err  <= 1'b0;
                end else if (haddr <= 13 && busy) begin
                    err <= 1'b1;
                end else begin
                    case (haddr)
                        1: begin
                            if (host_wdata[0]) begin
                                go   <= 1'b1;
                                busy <= 1'b1;
                            end
                        end
                        2, 3, 4, 5, 6, 7, 8, 9: cent[3'(haddr - 2)] <= host_wdata;
                        10: ram_addr <= host_wdata[addrWidth-1:0];
                        11: begin
                            ram_data      <= host_wdata;
                            ram_load      <= 1'b1;
                            ram_load_addr <= ram_addr;
                            ram_load_data <= host_wdata[ram_word_len-1:0];
                            ram_addr      <= ram_addr + 1'b1;
                        end
                        12:      first_reg <= host_wdata;
                        13:      last_reg  <= host_wdata;
                        default: ;
                    endcase
                end
            end
            if (busy && reg_write && cidx >= 2 && cidx <= 9) begin
                cent[3'(cidx - 2)] <= ctrl_wdata;
            end
            if (rise) begin
                go   <= 1'b0;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kmeans_regfile.sv
// Self-checking bench for kmeans_regfile: directed scenarios plus a randomized
// mix of host, controller and interrupt activity against a register-map model.
module tb_kmeans_regfile;

    localparam int DW = 91;
    localparam int AW = 9;
    localparam int RW = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_req = 1'b0;
    logic          host_wr = 1'b0;
    logic [3:0]    host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          irq;
    logic          go;
    logic [3:0]    reg_num = '0;
    logic          reg_write = 1'b0;
    logic [DW-1:0] ctrl_wdata = '0;
    logic [DW-1:0] ctrl_rdata;
    logic          interupt = 1'b0;
    logic [AW-1:0] first_ram_addr;
    logic [AW-1:0] last_ram_addr;
    logic          ram_load;
    logic [AW-1:0] ram_load_addr;
    logic [RW-1:0] ram_load_data;

    int total = 0;
    int bad = 0;

    // Model of the architectural register contents.
    logic [DW-1:0] m_cent [8];
    logic [DW-1:0] m_ram_data, m_first, m_last;
    logic [AW-1:0] m_ram_addr;
    logic          m_go, m_busy, m_done, m_err;

    kmeans_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .irq(irq), .go(go),
        .reg_num(reg_num), .reg_write(reg_write), .ctrl_wdata(ctrl_wdata),
        .ctrl_rdata(ctrl_rdata), .interupt(interupt),
        .first_ram_addr(first_ram_addr), .last_ram_addr(last_ram_addr),
        .ram_load(ram_load), .ram_load_addr(ram_load_addr),
        .ram_load_data(ram_load_data)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and log any mismatch.
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) m_cent[i] = '0;
        m_ram_data = '0; m_first = '0; m_last = '0; m_ram_addr = '0;
        m_go = 0; m_busy = 0; m_done = 0; m_err = 0;
    endtask

    function automatic logic [DW-1:0] modelRead(input int idx);
        if (idx == 0) return DW'(int'(m_done) + 2 * int'(m_busy) + 4 * int'(m_err));
        if (idx == 1) return DW'(m_go);
        if (idx >= 2 && idx <= 9) return m_cent[idx - 2];
        if (idx == 10) return DW'(m_ram_addr);
        if (idx == 11) return m_ram_data;
        if (idx == 12) return m_first;
        if (idx == 13) return m_last;
        return '0;
    endfunction

    function automatic logic [DW-1:0] randData();
        return DW'({$urandom, $urandom, $urandom});
    endfunction

    task automatic checkFlags(input string tag);
        checkOutput({tag, "_go"}, go, m_go);
        checkOutput({tag, "_irq"}, irq, m_done);
        checkOutput({tag, "_first"}, first_ram_addr, m_first[AW-1:0]);
        checkOutput({tag, "_last"}, last_ram_addr, m_last[AW-1:0]);
    endtask

    // One complete host access: request, ack one cycle later, ack drops after.
    task automatic applyStimulus(input logic wr, input int idx, input logic [DW-1:0] data);
        logic [DW-1:0] exp_rd;
        logic          exp_load;
        logic [AW-1:0] exp_laddr;
        exp_load  = 1'b0;
        exp_laddr = '0;
        @(negedge clk);
        host_req = 1'b1; host_wr = wr; host_addr = 4'(idx); host_wdata = data;
        exp_rd = modelRead(idx);
        if (wr) begin
            if (idx == 0) begin
                if (data[0]) m_done = 0;
                if (data[2]) m_err = 0;
            end else if (idx <= 13 && m_busy) begin
                m_err = 1;
            end else if (idx == 1) begin
                if (data[0]) begin m_go = 1; m_busy = 1; end
            end else if (idx >= 2 && idx <= 9) begin
                m_cent[idx - 2] = data;
            end else if (idx == 10) begin
                m_ram_addr = data[AW-1:0];
            end else if (idx == 11) begin
                m_ram_data = data;
                exp_load   = 1'b1;
                exp_laddr  = m_ram_addr;
                m_ram_addr = AW'((int'(m_ram_addr) + 1) % (1 << AW));
            end else if (idx == 12) begin
                m_first = data;
            end else if (idx == 13) begin
                m_last = data;
            end
        end
        @(posedge clk); #1;
        checkOutput("ack", host_ack, 1);
        if (!wr) checkOutput("rdata", host_rdata, exp_rd);
        checkOutput("ram_load", ram_load, exp_load);
        if (exp_load) begin
            checkOutput("ram_load_addr", ram_load_addr, exp_laddr);
            checkOutput("ram_load_data", ram_load_data, data[RW-1:0]);
        end
        checkFlags("acc");
        @(negedge clk);
        host_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("ack_single", host_ack, 0);
        checkOutput("ram_load_single", ram_load, 0);
    endtask

    // Controller write strobe with combinational read-back before and after.
    task automatic ctrlWrite(input int idx, input logic [DW-1:0] data);
        @(negedge clk);
        reg_write = 1'b1; reg_num = 4'(idx); ctrl_wdata = data;
        #1 checkOutput("ctrl_rdata_pre", ctrl_rdata, (idx >= 2 && idx <= 9) ? m_cent[idx - 2] : '0);
        if (m_busy && idx >= 2 && idx <= 9) m_cent[idx - 2] = data;
        @(negedge clk);
        reg_write = 1'b0;
        #1 checkOutput("ctrl_rdata_post", ctrl_rdata, (idx >= 2 && idx <= 9) ? m_cent[idx - 2] : '0);
        checkFlags("ctrl");
    endtask

    // Raise the controller done level and check the handshake reacts on that edge.
    task automatic pulseIrq();
        @(negedge clk);
        interupt = 1'b1;
        m_go = 0; m_busy = 0; m_done = 1;
        @(posedge clk); #1;
        checkFlags("irq_edge");
        @(negedge clk);
        interupt = 1'b0;
    endtask

    initial begin
        int kind, idx;
        logic [AW-1:0] first_before;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ack", host_ack, 0);
        checkOutput("rst_rdata", host_rdata, 0);
        checkOutput("rst_ram_load", ram_load, 0);
        checkFlags("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Centroid write/read round trip
        applyStimulus(1, 4, DW'(16'h1234));
        applyStimulus(0, 4, '0);

        // Held request completes on alternate cycles
        @(negedge clk);
        host_req = 1'b1; host_wr = 1'b0; host_addr = 4'd4;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("held_ack", host_ack, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        host_req = 1'b0;
        @(posedge clk);

        // Preload wraps the RAM address
        applyStimulus(1, 10, DW'(511));
        applyStimulus(1, 11, DW'(5));
        applyStimulus(1, 11, DW'(6));
        applyStimulus(0, 10, '0);

        // Start, hold go for twenty cycles, then finish
        applyStimulus(1, 12, DW'(9'h0A5));
        applyStimulus(1, 1, DW'(1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("go_hold", go, 1);
        end
        pulseIrq();
        applyStimulus(0, 0, '0);
        applyStimulus(1, 0, DW'(1));

        // Busy: host and controller collide on cent_1; reg 12 and 15 handling
        applyStimulus(1, 1, DW'(1));
        @(negedge clk);
        host_req = 1'b1; host_wr = 1'b1; host_addr = 4'd2; host_wdata = DW'(8'h55);
        reg_write = 1'b1; reg_num = 4'd2; ctrl_wdata = DW'(8'hAB);
        m_err = 1; m_cent[0] = DW'(8'hAB);
        @(posedge clk); #1;
        checkOutput("collide_ack", host_ack, 1);
        @(negedge clk);
        host_req = 1'b0; reg_write = 1'b0;
        @(posedge clk);
        applyStimulus(0, 2, '0);
        applyStimulus(0, 0, '0);
        first_before = first_ram_addr;
        ctrlWrite(12, DW'(9'h1FF));
        checkOutput("first_kept", first_ram_addr, first_before);
        applyStimulus(0, 15, '0);
        pulseIrq();

        // Randomized mix
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 15);
            case (kind)
                0, 1, 2: applyStimulus(1, idx, randData());
                3, 4:    applyStimulus(0, idx, '0);
                5, 6:    ctrlWrite(idx, randData());
                7:       applyStimulus(1, 1, DW'(1));
                8:       pulseIrq();
                default: applyStimulus(1, 0, DW'($urandom_range(0, 7)));
            endcase
        end

        // Reset during an active run with a request on the reset edge
        applyStimulus(1, 13, DW'(9'h033));
        applyStimulus(1, 1, DW'(1));
        @(negedge clk);
        host_req = 1'b1; host_wr = 1'b0; host_addr = 4'd0;
        rst_n = 1'b0;
        modelReset();
        @(posedge clk); #1;
        checkOutput("rst_mid_ack", host_ack, 0);
        checkOutput("rst_mid_rdata", host_rdata, 0);
        checkOutput("rst_mid_load", ram_load, 0);
        checkFlags("rst_mid");
        @(negedge clk);
        host_req = 1'b0;
        reg_num = 4'd2;
        #1 checkOutput("rst_mid_ctrl", ctrl_rdata, 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, '0);
        applyStimulus(0, 4, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kmeans_regfile.md
KMEANS_REGFILE -- requirements
Module: kmeans_regfile

Interface
REQ-001 SHALL have parameter dataWidth, default 91, the centroid/register data width (7 coords x 13 bits).
REQ-002 SHALL have parameter reg_amount, default 4, the register index width.
REQ-003 SHALL have parameter addrWidth, default 9, the RAM address width.
REQ-004 SHALL have parameter ram_word_len, default 50, the RAM data word width.
REQ-005 SHALL use one clock; reset is synchronous and active-low, with ports named clk and rst_n.
REQ-006 Port list:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- host_req  input  1  host access request
- host_wr  input  1  1 = write, 0 = read
- host_addr  input  reg_amount  host register index
- host_wdata  input  dataWidth  host write data
- host_ack  output  1  one-cycle access completion
- host_rdata  output  dataWidth  read data, valid with host_ack
- irq  output  1  host interrupt
- go  output  1  start level to controller
- reg_num  input  reg_amount  controller register index
- reg_write  input  1  controller write strobe
- ctrl_wdata  input  dataWidth  new centroid from convergence block
- ctrl_rdata  output  dataWidth  register[reg_num], combinational
- interupt  input  1  controller done level
- first_ram_addr  output  addrWidth  point window start
- last_ram_addr  output  addrWidth  point window end
- ram_load  output  1  one-cycle RAM preload strobe
- ram_load_addr  output  addrWidth  preload address
- ram_load_data  output  ram_word_len  preload data

Function
REQ-007 Register map SHALL be: 0 status, 1 GO, 2-9 cent_1..cent_8, 10 ram_addr, 11 ram_data, 12 first_ram_addr, 13 last_ram_addr; indices 14-15 read 0, ignore writes, still ack.
REQ-008 Host accesses SHALL be accepted when host_req=1 and no ack is pending; host_ack SHALL be asserted exactly 1 cycle later for 1 cycle, with host_rdata registered at that time; host_req held high SHALL yield an ack on every second cycle.
REQ-009 Status register bits SHALL be: [0] done (W1C), [1] busy (RO), [2] err (W1C), all other bits 0.
REQ-010 Host write of 1 to GO[0] while busy=0 SHALL set go and busy on the next cycle; GO SHALL read back {0..,go}.
REQ-011 A rising edge of interupt (compared with the previous-cycle sample) SHALL clear go and busy and set done in the same cycle; irq SHALL equal done.
REQ-012 While busy=1, host writes to indices 1-13 SHALL be dropped, acked, and set err.
REQ-013 While busy=1, reg_write=1 with reg_num in 2-9 SHALL load ctrl_wdata into that centroid; reg_write with any other index SHALL be ignored; reg_write while busy=0 SHALL be ignored.
REQ-014 If a host write and a controller write target the same register in the same cycle, the controller write SHALL win and the host write SHALL set err.
REQ-015 A host write to ram_data (busy=0) SHALL store the data and, on the next cycle, pulse ram_load with ram_load_addr=ram_addr and ram_load_data=ram_data[ram_word_len-1:0]; ram_addr SHALL then increment by 1, wrapping from 2^addrWidth-1 to 0.
REQ-016 first_ram_addr and last_ram_addr SHALL drive the low addrWidth bits of registers 12 and 13 continuously.
REQ-017 ctrl_rdata SHALL return 0 for indices outside 2-9.

Reset
REQ-018 With rst_n=0 at a clk edge, the following SHALL all be 0: every register, go, busy, done, err, irq, host_ack, host_rdata, ram_load, and the interupt edge sampler.
REQ-019 Reset asserted mid-operation SHALL abort the pending ack and ram_load, and SHALL not be cleared until the first clk edge with rst_n=1.

Verification
REQ-020 Host writes cent_3=0x1234, then reads index 4 -> host_ack occurs 1 cycle after each request, and host_rdata=0x1234.
REQ-021 Host writes GO=1, then interupt rises after 20 cycles -> go=1 for exactly those cycles, then go=0, done=1, irq=1; a write of 0x1 to status clears irq the next cycle.
REQ-022 Busy; host writes cent_1 and controller writes cent_1=0xAB in the same cycle -> cent_1=0xAB and status err=1.
REQ-023 Idle; ram_addr=511, two host writes to ram_data (5, 6) -> ram_load at address 511 with data 5, then at address 0 with data 6; ram_addr ends at 1.
REQ-024 Busy; reg_num=12 with reg_write=1 -> first_ram_addr is unchanged; a host read of index 15 returns 0 with an ack.
REQ-025 Reset pulsed while an ack is pending -> no ack is issued, and all outputs read 0 after the reset edge.
